// File: rtl/alu_ctrl_pkg.sv
// Shared definitions for the ALU sequencing front-end: op codes, shift-fill
// codes, controller states and the per-op latency table.
package alu_ctrl_pkg;

    // Wait cycles the ALU needs for each op class (all within 1..15)
    localparam logic [3:0] LAT_LOGIC = 4'd1;
    localparam logic [3:0] LAT_ADD   = 4'd2;
    localparam logic [3:0] LAT_MUL   = 4'd3;
    localparam logic [3:0] LAT_SHIFT = 4'd3;

    localparam logic [2:0] ALU_FWD   = 3'b000;
    localparam logic [2:0] ALU_ADD   = 3'b001;
    localparam logic [2:0] ALU_AND   = 3'b010;
    localparam logic [2:0] ALU_OR    = 3'b011;
    localparam logic [2:0] ALU_MUL   = 3'b100;
    localparam logic [2:0] ALU_SHIFT = 3'b101;

    localparam logic [1:0] RS_LOGIC  = 2'b00;
    localparam logic [1:0] RS_ARITH  = 2'b01;
    localparam logic [1:0] RS_ROT    = 2'b10;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        WAIT = 2'b01,
        RESP = 2'b10
    } state_t;

    // Latency of an op; 0 marks an op code the ALU does not implement
    function automatic logic [3:0] op_latency(input logic [2:0] sel);
        logic [3:0] lat;
        case (sel)
            ALU_FWD, ALU_AND, ALU_OR: lat = LAT_LOGIC;
            ALU_ADD:                  lat = LAT_ADD;
            ALU_MUL:                  lat = LAT_MUL;
            ALU_SHIFT:                lat = LAT_SHIFT;
            default:                  lat = 4'd0;
        endcase
        return lat;
    endfunction

endpackage

// File: rtl/rr_arbiter_2.sv
// Two-requester round-robin grant. Owns the last-granted index, which only
// advances when the controller actually accepts a request.
module rr_arbiter_2 (
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] req,
    input  logic       accept,
    output logic       grant
);

    logic last_grant;

    // Contention goes to whoever was not served last; a lone requester wins
    always_comb begin
        if (req == 2'b11) grant = ~last_grant;
        else              grant = req[1];
    end

    // Remember the winner of each accepted request
    always_ff @(posedge clk) begin
        if (reset)       last_grant <= 1'b1;
        else if (accept) last_grant <= grant;
    end

endmodule

// File: rtl/alu_arbiter.sv
// Sequencing front-end for the 8-bit ALU: arbitrates two requesters, holds
// the ALU inputs for the op latency, captures the result and returns it on
// a valid/ready response channel routed to the granted requester.
module alu_arbiter
    import alu_ctrl_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] req_valid,
    output logic [1:0] req_ready,
    input  logic [7:0] req0_data1,
    input  logic [7:0] req0_data2,
    input  logic [2:0] req0_select,
    input  logic       req0_r,
    input  logic [1:0] req0_rs,
    input  logic [7:0] req1_data1,
    input  logic [7:0] req1_data2,
    input  logic [2:0] req1_select,
    input  logic       req1_r,
    input  logic [1:0] req1_rs,
    output logic [1:0] resp_valid,
    input  logic [1:0] resp_ready,
    output logic [7:0] resp_result,
    output logic       resp_zero,
    output logic       resp_err,
    output logic [7:0] alu_data1,
    output logic [7:0] alu_data2,
    output logic [2:0] alu_select,
    output logic       alu_r,
    output logic [1:0] alu_rs,
    input  logic [7:0] alu_result
);

    state_t     state;
    state_t     next_state;
    logic [3:0] cnt;
    logic       grant;
    logic       resp_gnt;
    logic       accept;
    logic [7:0] sel_data1;
    logic [7:0] sel_data2;
    logic [2:0] sel_select;
    logic       sel_r;
    logic [1:0] sel_rs;
    logic [3:0] sel_lat;

    rr_arbiter_2 u_rr (
        .clk    (clk),
        .reset  (reset),
        .req    (req_valid),
        .accept (accept),
        .grant  (grant)
    );

    // Requests are only looked at in IDLE, and never while reset is held
    assign accept = (state == IDLE) && (req_valid != 2'b00) && !reset;

    // Route the granted requester's fields toward the operand register
    always_comb begin
        if (grant) begin
            sel_data1  = req1_data1;
            sel_data2  = req1_data2;
            sel_select = req1_select;
            sel_r      = req1_r;
            sel_rs     = req1_rs;
        end else begin
            sel_data1  = req0_data1;
            sel_data2  = req0_data2;
            sel_select = req0_select;
            sel_r      = req0_r;
            sel_rs     = req0_rs;
        end
        sel_lat = op_latency(sel_select);
    end

    // Controller state register
    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= next_state;
    end

    // Next state plus the accept and response handshake strobes
    always_comb begin
        next_state = state;
        req_ready  = 2'b00;
        resp_valid = 2'b00;
        case (state)
            IDLE: begin
                if (accept) begin
                    req_ready  = grant ? 2'b10 : 2'b01;
                    next_state = (sel_lat == 4'd0) ? RESP : WAIT;
                end
            end
            WAIT: begin
                if (cnt == 4'd1) next_state = RESP;
            end
            RESP: begin
                resp_valid = resp_gnt ? 2'b10 : 2'b01;
                if (resp_ready[resp_gnt]) next_state = IDLE;
            end
            default: next_state = IDLE;
        endcase
    end

    // Operand register feeding the ALU, latency counter and result capture.
    // Unsupported ops leave the ALU lines untouched and answer immediately.
    always_ff @(posedge clk) begin
        if (reset) begin
            alu_data1   <= 8'h00;
            alu_data2   <= 8'h00;
            alu_select  <= 3'b000;
            alu_r       <= 1'b0;
            alu_rs      <= 2'b00;
            cnt         <= 4'd0;
            resp_gnt    <= 1'b0;
            resp_result <= 8'h00;
            resp_zero   <= 1'b0;
            resp_err    <= 1'b0;
        end else if (accept) begin
            resp_gnt <= grant;
            if (sel_lat == 4'd0) begin
                resp_err    <= 1'b1;
                resp_result <= 8'h00;
                resp_zero   <= 1'b0;
            end else begin
                alu_data1  <= sel_data1;
                alu_data2  <= sel_data2;
                alu_select <= sel_select;
                alu_r      <= sel_r;
                alu_rs     <= sel_rs;
                cnt        <= sel_lat;
                resp_err   <= 1'b0;
            end
        end else if (state == WAIT) begin
            cnt <= cnt - 4'd1;
            if (cnt == 4'd1) begin
                resp_result <= alu_result;
                resp_zero   <= (alu_result == 8'h00);
            end
        end
    end

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter with a behavioural model of the 8-bit ALU.
module tb_alu_arbiter;

    logic       clk = 1'b0;
    logic       reset;
    logic [1:0] req_valid;
    logic [1:0] req_ready;
    logic [7:0] req0_data1, req0_data2, req1_data1, req1_data2;
    logic [2:0] req0_select, req1_select;
    logic       req0_r, req1_r;
    logic [1:0] req0_rs, req1_rs;
    logic [1:0] resp_valid;
    logic [1:0] resp_ready;
    logic [7:0] resp_result;
    logic       resp_zero;
    logic       resp_err;
    logic [7:0] alu_data1, alu_data2;
    logic [2:0] alu_select;
    logic       alu_r;
    logic [1:0] alu_rs;
    logic [7:0] alu_result;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    alu_arbiter dut (
        .clk         (clk),
        .reset       (reset),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req0_data1  (req0_data1),
        .req0_data2  (req0_data2),
        .req0_select (req0_select),
        .req0_r      (req0_r),
        .req0_rs     (req0_rs),
        .req1_data1  (req1_data1),
        .req1_data2  (req1_data2),
        .req1_select (req1_select),
        .req1_r      (req1_r),
        .req1_rs     (req1_rs),
        .resp_valid  (resp_valid),
        .resp_ready  (resp_ready),
        .resp_result (resp_result),
        .resp_zero   (resp_zero),
        .resp_err    (resp_err),
        .alu_data1   (alu_data1),
        .alu_data2   (alu_data2),
        .alu_select  (alu_select),
        .alu_r       (alu_r),
        .alu_rs      (alu_rs),
        .alu_result  (alu_result)
    );

    // Behavioural ALU: DATA2[2:0] is the shift amount
    logic [15:0]       prod;
    logic [15:0]       rot2;
    logic signed [7:0] sdat;
    always_comb begin
        prod = {8'h00, alu_data1} * {8'h00, alu_data2};
        rot2 = {alu_data1, alu_data1} >> alu_data2[2:0];
        sdat = alu_data1;
        case (alu_select)
            3'b000: alu_result = alu_data1;
            3'b001: alu_result = alu_data1 + alu_data2;
            3'b010: alu_result = alu_data1 & alu_data2;
            3'b011: alu_result = alu_data1 | alu_data2;
            3'b100: alu_result = prod[7:0];
            3'b101: begin
                if (!alu_r)               alu_result = alu_data1 << alu_data2[2:0];
                else if (alu_rs == 2'b01) alu_result = sdat >>> alu_data2[2:0];
                else if (alu_rs == 2'b10) alu_result = rot2[7:0];
                else                      alu_result = alu_data1 >> alu_data2[2:0];
            end
            default: alu_result = 8'h00;
        endcase
    end

    typedef struct {
        int         who;
        logic [2:0] sel;
        logic [7:0] d1;
        logic [7:0] d2;
        logic       r;
        logic [1:0] rs;
        logic [7:0] res;
        logic       z;
        int         lat;
    } vec_t;

    vec_t vt[10];

    task automatic chk(input string tag, input string what, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s/%s: got 0x%0h expected 0x%0h", tag, what, act, exp);
        end
    endtask

    task automatic set_req(input int who, input logic [2:0] sel, input logic [7:0] d1, input logic [7:0] d2,
                           input logic r, input logic [1:0] rs);
        if (who == 0) begin
            req0_select = sel; req0_data1 = d1; req0_data2 = d2; req0_r = r; req0_rs = rs;
        end else begin
            req1_select = sel; req1_data1 = d1; req1_data2 = d2; req1_r = r; req1_rs = rs;
        end
    endtask

    // Called in IDLE with requests already driven; RESP_READY is expected high
    task automatic run_txn(input string tag, input logic [1:0] exp_rdy, input int lat,
                           input logic [2:0] a_sel, input logic [7:0] a_d1, input logic [7:0] a_d2,
                           input logic a_r, input logic [1:0] a_rs,
                           input logic [7:0] exp_res, input logic exp_z, input logic exp_e,
                           input logic drop_valid);
        int k;
        #1;
        chk(tag, "req_ready", 32'(req_ready), 32'(exp_rdy));
        @(posedge clk); #1;
        if (drop_valid) req_valid = 2'b00;
        k = 1;
        while (resp_valid == 2'b00 && k <= 20) begin
            chk(tag, "alu_select", 32'(alu_select), 32'(a_sel));
            chk(tag, "alu_data1", 32'(alu_data1), 32'(a_d1));
            chk(tag, "alu_data2", 32'(alu_data2), 32'(a_d2));
            chk(tag, "alu_r_rs", 32'({alu_r, alu_rs}), 32'({a_r, a_rs}));
            @(posedge clk); #1;
            k++;
        end
        chk(tag, "resp_latency", 32'(k), 32'(lat + 1));
        chk(tag, "resp_valid", 32'(resp_valid), 32'(exp_rdy));
        chk(tag, "resp_result", 32'(resp_result), 32'(exp_res));
        chk(tag, "resp_zero", 32'(resp_zero), 32'(exp_z));
        chk(tag, "resp_err", 32'(resp_err), 32'(exp_e));
        @(posedge clk); #1;
        chk(tag, "resp_valid_drop", 32'(resp_valid), 32'(0));
    endtask

    initial begin
        vt[0] = '{0, 3'b001, 8'hFF, 8'h01, 1'b0, 2'b00, 8'h00, 1'b1, 2};
        vt[1] = '{1, 3'b100, 8'h05, 8'h07, 1'b0, 2'b00, 8'h23, 1'b0, 3};
        vt[2] = '{0, 3'b101, 8'h96, 8'h01, 1'b1, 2'b00, 8'h4B, 1'b0, 3};
        vt[3] = '{0, 3'b101, 8'h96, 8'h01, 1'b1, 2'b01, 8'hCB, 1'b0, 3};
        vt[4] = '{1, 3'b010, 8'hF0, 8'h3C, 1'b0, 2'b00, 8'h30, 1'b0, 1};
        vt[5] = '{0, 3'b011, 8'h00, 8'h00, 1'b0, 2'b00, 8'h00, 1'b1, 1};
        vt[6] = '{1, 3'b000, 8'hA5, 8'h5A, 1'b0, 2'b00, 8'hA5, 1'b0, 1};
        vt[7] = '{0, 3'b101, 8'h81, 8'h01, 1'b1, 2'b10, 8'hC0, 1'b0, 3};
        vt[8] = '{1, 3'b101, 8'h81, 8'h01, 1'b0, 2'b00, 8'h02, 1'b0, 3};
        vt[9] = '{0, 3'b100, 8'h10, 8'h10, 1'b0, 2'b00, 8'h00, 1'b1, 3};

        reset = 1'b1;
        req_valid = 2'b00;
        resp_ready = 2'b11;
        set_req(0, 3'b000, 8'h00, 8'h00, 1'b0, 2'b00);
        set_req(1, 3'b000, 8'h00, 8'h00, 1'b0, 2'b00);
        repeat (3) @(posedge clk);
        #1;
        chk("reset", "req_ready", 32'(req_ready), 32'(0));
        chk("reset", "resp_valid", 32'(resp_valid), 32'(0));
        chk("reset", "resp_result", 32'(resp_result), 32'(0));
        chk("reset", "resp_zero_err", 32'({resp_zero, resp_err}), 32'(0));
        chk("reset", "alu_data", 32'({alu_data1, alu_data2}), 32'(0));
        chk("reset", "alu_ctrl", 32'({alu_select, alu_r, alu_rs}), 32'(0));
        reset = 1'b0;

        // Both requesters contend continuously: grants 0, 1, 0
        set_req(0, 3'b001, 8'h01, 8'h02, 1'b0, 2'b00);
        set_req(1, 3'b001, 8'h10, 8'h20, 1'b0, 2'b00);
        req_valid = 2'b11;
        run_txn("rr1", 2'b01, 2, 3'b001, 8'h01, 8'h02, 1'b0, 2'b00, 8'h03, 1'b0, 1'b0, 1'b0);
        run_txn("rr2", 2'b10, 2, 3'b001, 8'h10, 8'h20, 1'b0, 2'b00, 8'h30, 1'b0, 1'b0, 1'b0);
        run_txn("rr3", 2'b01, 2, 3'b001, 8'h01, 8'h02, 1'b0, 2'b00, 8'h03, 1'b0, 1'b0, 1'b1);

        // Single-requester table
        for (int i = 0; i < 10; i++) begin
            set_req(vt[i].who, vt[i].sel, vt[i].d1, vt[i].d2, vt[i].r, vt[i].rs);
            req_valid = (vt[i].who == 0) ? 2'b01 : 2'b10;
            run_txn($sformatf("vec%0d", i), req_valid, vt[i].lat, vt[i].sel, vt[i].d1, vt[i].d2,
                    vt[i].r, vt[i].rs, vt[i].res, vt[i].z, 1'b0, 1'b1);
        end

        // Unsupported op with the response held off for several cycles
        set_req(0, 3'b110, 8'h12, 8'h34, 1'b0, 2'b00);
        req_valid = 2'b01;
        resp_ready = 2'b00;
        #1;
        chk("err", "req_ready", 32'(req_ready), 32'(2'b01));
        @(posedge clk); #1;
        set_req(0, 3'b001, 8'h01, 8'h02, 1'b0, 2'b00);
        set_req(1, 3'b001, 8'h40, 8'h04, 1'b0, 2'b00);
        req_valid = 2'b11;
        for (int c = 0; c < 5; c++) begin
            chk("err_hold", "resp_valid", 32'(resp_valid), 32'(2'b01));
            chk("err_hold", "resp_err", 32'(resp_err), 32'(1));
            chk("err_hold", "resp_result", 32'(resp_result), 32'(0));
            chk("err_hold", "resp_zero", 32'(resp_zero), 32'(0));
            chk("err_hold", "req_ready", 32'(req_ready), 32'(0));
            chk("err_hold", "alu_kept", 32'({alu_select, alu_data1, alu_data2}), 32'({3'b100, 8'h10, 8'h10}));
            @(posedge clk); #1;
        end
        resp_ready = 2'b10;
        @(posedge clk); #1;
        chk("err_wrong_ready", "resp_valid", 32'(resp_valid), 32'(2'b01));
        resp_ready = 2'b01;
        @(posedge clk); #1;
        resp_ready = 2'b11;
        run_txn("rr_after_err", 2'b10, 2, 3'b001, 8'h40, 8'h04, 1'b0, 2'b00, 8'h44, 1'b0, 1'b0, 1'b1);

        // Reset in the middle of a multiply
        set_req(1, 3'b100, 8'h05, 8'h07, 1'b0, 2'b00);
        req_valid = 2'b10;
        #1;
        chk("rst_mid", "req_ready", 32'(req_ready), 32'(2'b10));
        @(posedge clk); #1;
        req_valid = 2'b00;
        @(posedge clk); #1;
        chk("rst_mid", "alu_select_wait", 32'(alu_select), 32'(3'b100));
        reset = 1'b1;
        set_req(0, 3'b001, 8'h21, 8'h12, 1'b0, 2'b00);
        set_req(1, 3'b001, 8'h0F, 8'h0F, 1'b0, 2'b00);
        req_valid = 2'b11;
        @(posedge clk); #1;
        chk("rst_mid", "resp_valid", 32'(resp_valid), 32'(0));
        chk("rst_mid", "alu_all", 32'({alu_data1, alu_data2, alu_select, alu_r, alu_rs}), 32'(0));
        chk("rst_mid", "req_ready_in_reset", 32'(req_ready), 32'(0));
        @(posedge clk); #1;
        chk("rst_mid", "req_ready_in_reset2", 32'(req_ready), 32'(0));
        reset = 1'b0;
        run_txn("post_reset", 2'b01, 2, 3'b001, 8'h21, 8'h12, 1'b0, 2'b00, 8'h33, 1'b0, 1'b0, 1'b1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
